// File: rtl/softmax_out_wdma_pkg.sv
// Shared constants, packet layout and FSM encoding for the softmax write DMA.
// Optional feature macro: SOFTMAX_WDMA_WAIT_RSP_EN.
package softmax_out_wdma_pkg;
  localparam int MAX_DAT_DW = 8;
  localparam int TOUT = 8;
  localparam int LOG2_TOUT = 3;
  localparam int LOG2_CH = 10;
  localparam int LOG2_H = 11;
  localparam int LOG2_W = 11;
  localparam int CHG_W = LOG2_CH - LOG2_TOUT;
  localparam int AXI_BURST_LEN = 16;
  localparam int LOG2_AXI_BURST_LEN = 4;

  localparam int DAT_W_DEF = MAX_DAT_DW * TOUT;
  localparam int BEAT_BYTES_DEF = DAT_W_DEF / 8;

  localparam int PD_ADDR_LSB = DAT_W_DEF;
  localparam int PD_LEN_LSB = PD_ADDR_LSB + 32;
  localparam int PD_FIRST = PD_LEN_LSB + LOG2_AXI_BURST_LEN;
  localparam int PD_LAST = PD_FIRST + 1;
  localparam int PD_W = PD_LAST + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_WAIT,
    ST_DONE
  } wdma_st_e;
endpackage

// File: rtl/softmax_out_wdma_addr_gen.sv
// Burst walker: x/y/c position, row and surface base accumulators,
// current burst address, burst length and final-burst flag.
module wdma_addr_gen
  import softmax_out_wdma_pkg::*;
#(
  parameter int BURST_LEN = AXI_BURST_LEN,
  parameter int LEN_W = LOG2_AXI_BURST_LEN,
  parameter int BEAT_BYTES = BEAT_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init,
  input  logic [CHG_W-1:0]  i_ch,
  input  logic [LOG2_H-1:0] i_h,
  input  logic [LOG2_W-1:0] i_w,
  input  logic [31:0]       i_base,
  input  logic [25:0]       i_surf,
  input  logic [15:0]       i_line,
  input  logic              i_adv,
  output logic [31:0]       o_addr,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_last_burst
);
  localparam int BB_SH = $clog2(BEAT_BYTES);

  logic [CHG_W-1:0]  r_ch, r_c;
  logic [LOG2_H-1:0] r_h, r_y;
  logic [LOG2_W-1:0] r_w, r_x;
  logic [25:0]       r_surf;
  logic [15:0]       r_line;
  logic [31:0]       r_row_base;
  logic [31:0]       r_surf_base;
  logic [31:0]       r_addr;

  logic [LOG2_W-1:0] w_rem;
  logic [LOG2_W-1:0] w_nb;
  logic [31:0]       w_step;
  logic [31:0]       w_line32;
  logic [31:0]       w_surf32;
  logic              w_row_end;
  logic              w_last_row;
  logic              w_last_c;

  assign w_rem = r_w - r_x;
  assign w_nb = (w_rem > LOG2_W'(BURST_LEN)) ? LOG2_W'(BURST_LEN) : w_rem;
  assign w_step = 32'(w_nb) << BB_SH;
  assign w_line32 = {16'b0, r_line};
  assign w_surf32 = {6'b0, r_surf};
  assign w_row_end = (w_rem == w_nb);
  assign w_last_row = (r_y == r_h - LOG2_H'(1));
  assign w_last_c = (r_c == r_ch - CHG_W'(1));

  assign o_addr = r_addr;
  assign o_len = LEN_W'(w_nb - LOG2_W'(1));
  assign o_last_burst = w_row_end & w_last_row & w_last_c;

  // Latch the job on init; step to the next burst on each burst completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch <= '0;
      r_h <= '0;
      r_w <= '0;
      r_surf <= '0;
      r_line <= '0;
      r_c <= '0;
      r_y <= '0;
      r_x <= '0;
      r_row_base <= '0;
      r_surf_base <= '0;
      r_addr <= '0;
    end else if (i_init) begin
      r_ch <= i_ch;
      r_h <= i_h;
      r_w <= i_w;
      r_surf <= i_surf;
      r_line <= i_line;
      r_c <= '0;
      r_y <= '0;
      r_x <= '0;
      r_row_base <= i_base;
      r_surf_base <= i_base;
      r_addr <= i_base;
    end else if (i_adv) begin
      if (!w_row_end) begin
        r_x <= r_x + w_nb;
        r_addr <= r_addr + w_step;
      end else if (!w_last_row) begin
        r_x <= '0;
        r_y <= r_y + LOG2_H'(1);
        r_row_base <= r_row_base + w_line32;
        r_addr <= r_row_base + w_line32;
      end else begin
        r_x <= '0;
        r_y <= '0;
        r_c <= r_c + CHG_W'(1);
        r_surf_base <= r_surf_base + w_surf32;
        r_row_base <= r_surf_base + w_surf32;
        r_addr <= r_surf_base + w_surf32;
      end
    end
  end
endmodule

// File: rtl/softmax_out_wdma.sv
// Softmax output write DMA: stream beats into MCIF write bursts.
// Optional macro SOFTMAX_WDMA_WAIT_RSP_EN: wait for all burst responses.
module softmax_out_wdma
  import softmax_out_wdma_pkg::*;
#(
  parameter int DAT_W = DAT_W_DEF,
  parameter int BURST_LEN = AXI_BURST_LEN,
  parameter int LEN_W = LOG2_AXI_BURST_LEN,
  parameter int BEAT_BYTES = DAT_W / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHG_W-1:0]          ch_div_Tout,
  input  logic [LOG2_H-1:0]         h,
  input  logic [LOG2_W-1:0]         w,
  input  logic [31:0]               base_addr,
  input  logic [25:0]               surface_stride,
  input  logic [15:0]               line_stride,
  input  logic                      dat_in_vld,
  input  logic [DAT_W-1:0]          dat_in_pd,
  output logic                      dat_in_rdy,
  output logic                      wr_req_vld,
  input  logic                      wr_req_rdy,
  output logic [2+LEN_W+32+DAT_W-1:0] wr_req_pd,
  input  logic                      wr_rsp_complete,
  output logic                      wdma_done,
  output logic                      busy
);
  wdma_st_e         r_state;
  logic [LEN_W-1:0] r_beat;
  logic             r_done;
  logic             r_busy;

  logic             w_in_burst;
  logic             w_fire;
  logic             w_first;
  logic             w_last;
  logic             w_adv;
  logic             w_init;
  logic             w_zero;
  logic             w_last_burst;
  logic             w_rsp_idle;
  logic [31:0]      w_addr;
  logic [LEN_W-1:0] w_len;

  assign w_in_burst = (r_state == ST_BURST);
  assign wr_req_vld = dat_in_vld & w_in_burst;
  assign dat_in_rdy = wr_req_rdy & w_in_burst;
  assign w_fire = dat_in_vld & wr_req_rdy & w_in_burst;
  assign w_first = (r_beat == '0);
  assign w_last = (r_beat == w_len);
  assign w_adv = w_fire & w_last;
  assign w_init = start & (r_state == ST_IDLE);
  assign w_zero = (ch_div_Tout == '0) | (h == '0) | (w == '0);
  assign wr_req_pd = {w_last, w_first, w_len, w_addr, dat_in_pd};
  assign wdma_done = r_done;
  assign busy = r_busy;

  wdma_addr_gen #(
    .BURST_LEN (BURST_LEN),
    .LEN_W     (LEN_W),
    .BEAT_BYTES(BEAT_BYTES)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_init      (w_init),
    .i_ch        (ch_div_Tout),
    .i_h         (h),
    .i_w         (w),
    .i_base      (base_addr),
    .i_surf      (surface_stride),
    .i_line      (line_stride),
    .i_adv       (w_adv),
    .o_addr      (w_addr),
    .o_len       (w_len),
    .o_last_burst(w_last_burst)
  );

`ifdef SOFTMAX_WDMA_WAIT_RSP_EN
  logic [LEN_W+3:0] r_outst;
  logic             w_dec;

  assign w_dec = wr_rsp_complete & (r_outst != '0);
  assign w_rsp_idle = (r_outst == '0);

  // Count bursts issued but not yet acknowledged by the memory side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
    end else if (w_init) begin
      r_outst <= '0;
    end else if (w_adv & !w_dec) begin
      r_outst <= r_outst + (LEN_W+4)'(1);
    end else if (!w_adv & w_dec) begin
      r_outst <= r_outst - (LEN_W+4)'(1);
    end
  end
`else
  logic w_unused_rsp;

  assign w_unused_rsp = wr_rsp_complete;
  assign w_rsp_idle = 1'b1;
`endif

  // Job sequencer with registered done pulse and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_beat <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_beat <= '0;
          if (start) begin
            if (w_zero) begin
              r_state <= ST_DONE;
              r_done <= 1'b1;
            end else begin
              r_state <= ST_BURST;
              r_busy <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_adv) begin
            r_beat <= '0;
            if (w_last_burst) begin
`ifdef SOFTMAX_WDMA_WAIT_RSP_EN
              r_state <= ST_WAIT;
`else
              r_state <= ST_DONE;
              r_done <= 1'b1;
              r_busy <= 1'b0;
`endif
            end
          end else if (w_fire) begin
            r_beat <= r_beat + LEN_W'(1);
          end
        end
        ST_WAIT: begin
          if (w_rsp_idle) begin
            r_state <= ST_DONE;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
